// File: rtl/hex_scroll_display.sv
// Multi-digit 7-segment message driver: buffers a nibble message and shows a
// DIGITS-wide window of it, either static or scrolling left through a blank gap.
module hex_scroll_display #(
    parameter int DIGITS      = 6,
    parameter int BUF_NIBBLES = 16,
    parameter int TICK_DIV    = 25000000
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             load,
    input  logic [4*BUF_NIBBLES-1:0]         data_in,
    input  logic [$clog2(BUF_NIBBLES+1)-1:0] len,
    input  logic                             scroll,
    input  logic                             pause,
    output logic [7*DIGITS-1:0]              hex,
    output logic                             step,
    output logic                             wrap
);
    localparam int LEN_W = $clog2(BUF_NIBBLES + 1);
    localparam int PW    = $clog2(BUF_NIBBLES + DIGITS);
    // LW holds L itself, which may be a power of two one past pos range
    localparam int LW    = $clog2(BUF_NIBBLES + DIGITS + 1);
    localparam int IW    = LW + 1;
    localparam int CW    = (BUF_NIBBLES > 1) ? $clog2(BUF_NIBBLES) : 1;
    localparam int PSW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [4*BUF_NIBBLES-1:0] msg;
    logic [LEN_W-1:0]         mlen;
    logic [PW-1:0]            pos;
    logic [PSW-1:0]           pre;
    logic [LW-1:0]            slen;
    logic                     tick;
    logic                     pos_last;
    logic [3:0]               ch [BUF_NIBBLES];
    logic [IW-1:0]            idx;
    logic [7*DIGITS-1:0]      nxt_hex;

    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'h0: glyph = 7'b0000001;
            4'h1: glyph = 7'b1001111;
            4'h2: glyph = 7'b0010010;
            4'h3: glyph = 7'b0000110;
            4'h4: glyph = 7'b1001100;
            4'h5: glyph = 7'b0100100;
            4'h6: glyph = 7'b0100000;
            4'h7: glyph = 7'b0001111;
            4'h8: glyph = 7'b0000000;
            4'h9: glyph = 7'b0001100;
            4'hA: glyph = 7'b0001000;
            4'hB: glyph = 7'b1100000;
            4'hC: glyph = 7'b0110001;
            4'hD: glyph = 7'b1000010;
            4'hE: glyph = 7'b0110000;
            default: glyph = 7'b0111000;
        endcase
    endfunction

    assign slen     = LW'(mlen) + LW'(DIGITS);
    assign tick     = (pre == PSW'(TICK_DIV - 1)) && scroll && !pause;
    assign pos_last = (LW'(pos) == slen - LW'(1));

    always_comb begin
        for (int k = 0; k < BUF_NIBBLES; k++)
            ch[k] = msg[4*(BUF_NIBBLES-1-k) +: 4];
    end

    // pos < L and j < DIGITS <= L, so one conditional subtract gives the modulo
    always_comb begin
        nxt_hex = '1;
        idx     = '0;
        for (int j = 0; j < DIGITS; j++) begin
            idx = IW'(pos) + IW'(j);
            if (idx >= IW'(slen))
                idx = idx - IW'(slen);
            if (idx < IW'(mlen))
                nxt_hex[7*(DIGITS-1-j) +: 7] = glyph(ch[idx[CW-1:0]]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            msg  <= '0;
            mlen <= '0;
            pos  <= '0;
            pre  <= '0;
            step <= 1'b0;
            wrap <= 1'b0;
            hex  <= '1;
        end else begin
            step <= 1'b0;
            wrap <= 1'b0;
            hex  <= nxt_hex;
            if (load) begin
                msg  <= data_in;
                mlen <= (len > LEN_W'(BUF_NIBBLES)) ? LEN_W'(BUF_NIBBLES) : len;
                pos  <= '0;
                pre  <= '0;
            end else if (!scroll) begin
                pos <= '0;
                pre <= '0;
            end else if (tick) begin
                pre  <= '0;
                step <= 1'b1;
                if (pos_last) begin
                    pos  <= '0;
                    wrap <= 1'b1;
                end else begin
                    pos <= pos + PW'(1);
                end
            end else if (!pause) begin
                pre <= pre + PSW'(1);
            end
        end
    end
endmodule

// File: tb/tb_hex_scroll_display.sv
// Randomized and directed bench for hex_scroll_display against a cycle-level
// reference model built from the stream/window rules.
module tb_hex_scroll_display;
    localparam int D  = 4;
    localparam int BN = 8;
    localparam int TD = 4;

    logic        clk = 1'b0;
    logic        rst_n, load, scroll, pause;
    logic [31:0] data_in;
    logic [3:0]  len;
    logic [27:0] hex;
    logic        step, wrap;

    int n_pass = 0, n_tot = 0;

    hex_scroll_display #(.DIGITS(D), .BUF_NIBBLES(BN), .TICK_DIV(TD)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .data_in(data_in), .len(len),
        .scroll(scroll), .pause(pause), .hex(hex), .step(step), .wrap(wrap)
    );

    always #5 clk = ~clk;

    // reference model state
    int          m_mlen, m_pos, m_pre;
    int          m_msg [BN];
    logic [27:0] e_hex;
    logic        e_step, e_wrap;

    function automatic logic [6:0] seg(input int v);
        logic [6:0] t [16];
        t = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
              7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
              7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
              7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
        return t[v];
    endfunction

    function automatic logic [27:0] window();
        logic [27:0] w;
        int L, k;
        w = '1;
        L = m_mlen + D;
        for (int j = 0; j < D; j++) begin
            k = (m_pos + j) % L;
            if (k < m_mlen) w[27-7*j -: 7] = seg(m_msg[k]);
        end
        return w;
    endfunction

    task automatic model_edge();
        if (!rst_n) begin
            m_mlen = 0; m_pos = 0; m_pre = 0;
            for (int i = 0; i < BN; i++) m_msg[i] = 0;
            e_hex = '1; e_step = 0; e_wrap = 0;
        end else begin
            e_hex  = window();
            e_step = 0;
            e_wrap = 0;
            if (load) begin
                for (int i = 0; i < BN; i++) m_msg[i] = int'(data_in[31-4*i -: 4]);
                m_mlen = (int'(len) > BN) ? BN : int'(len);
                m_pos = 0; m_pre = 0;
            end else if (!scroll) begin
                m_pos = 0; m_pre = 0;
            end else if (!pause) begin
                if (m_pre == TD - 1) begin
                    m_pre  = 0;
                    e_step = 1;
                    e_wrap = (m_pos == m_mlen + D - 1);
                    m_pos  = (m_pos + 1) % (m_mlen + D);
                end else begin
                    m_pre++;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // one clock: model steps on the edge, DUT outputs compared 1 time unit later
    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        chk("hex", 32'(hex), 32'(e_hex));
        chk("step", 32'(step), 32'(e_step));
        chk("wrap", 32'(wrap), 32'(e_wrap));
    endtask

    task automatic do_load(input logic [31:0] d, input logic [3:0] l, input logic s);
        data_in = d; len = l; scroll = s; load = 1;
        cyc();
        load = 0;
    endtask

    int nstep, nwrap;

    initial begin
        rst_n = 0; load = 0; scroll = 0; pause = 0; data_in = '0; len = '0;
        cyc(); cyc();
        chk("rst_hex", 32'(hex), 32'h0fff_ffff);
        rst_n = 1;

        // static window
        do_load(32'h1234_0000, 4'd4, 1'b0);
        cyc();
        chk("static_hex", 32'(hex), 32'({7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100}));
        nstep = 0;
        repeat (100) begin cyc(); nstep += int'(step); end
        chk("static_nostep", 32'(nstep), 32'd0);

        // scroll, L=6: one wrap and six steps per 24 cycles
        do_load(32'hAB00_0000, 4'd2, 1'b1);
        nstep = 0; nwrap = 0;
        repeat (24) begin cyc(); nstep += int'(step); nwrap += int'(wrap); end
        chk("scroll_steps", 32'(nstep), 32'd6);
        chk("scroll_wraps", 32'(nwrap), 32'd1);

        // reset mid-scroll
        repeat (5) cyc();
        rst_n = 0; cyc(); cyc();
        chk("midrst_hex", 32'(hex), 32'h0fff_ffff);
        rst_n = 1;
        cyc();
        chk("midrst_blank", 32'(hex), 32'h0fff_ffff);

        // pause after two prescaler counts
        do_load(32'hAB00_0000, 4'd2, 1'b1);
        cyc(); cyc();
        pause = 1; nstep = 0;
        repeat (10) begin cyc(); nstep += int'(step); end
        chk("pause_nostep", 32'(nstep), 32'd0);
        pause = 0;
        cyc();
        chk("pause_rel1", 32'(step), 32'd0);
        cyc();
        chk("pause_rel2", 32'(step), 32'd1);

        // load on the tick cycle
        for (int i = 0; i < 8 && m_pre != TD - 1; i++) cyc();
        do_load(32'hC0DE_0000, 4'd4, 1'b1);
        chk("coll_step", 32'(step), 32'd0);
        chk("coll_wrap", 32'(wrap), 32'd0);
        cyc(); cyc(); cyc();
        chk("coll_quiet", 32'(step), 32'd0);
        cyc();
        chk("coll_next", 32'(step), 32'd1);

        // len clamp: L=12, one wrap per 48 cycles
        do_load($urandom, 4'd15, 1'b1);
        nwrap = 0;
        repeat (48) begin cyc(); nwrap += int'(wrap); end
        chk("clamp_wraps", 32'(nwrap), 32'd1);

        // empty message: blank, wrap every 16 cycles
        do_load($urandom, 4'd0, 1'b1);
        nwrap = 0;
        repeat (32) begin cyc(); nwrap += int'(wrap); end
        chk("empty_wraps", 32'(nwrap), 32'd2);
        chk("empty_blank", 32'(hex), 32'h0fff_ffff);
        scroll = 0;
        cyc(); cyc();
        chk("empty_static", 32'(hex), 32'h0fff_ffff);

        // random traffic
        repeat (3000) begin
            rst_n   = ($urandom_range(0, 199) != 0);
            load    = ($urandom_range(0, 15) == 0);
            data_in = $urandom;
            len     = 4'($urandom_range(0, 15));
            scroll  = ($urandom_range(0, 3) != 0);
            pause   = ($urandom_range(0, 3) == 0);
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
